// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit. A right-shifting shift-add
// multiplier and a restoring divider share the hi/lo working registers and a
// single iteration counter, so every operation has the same latency.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            we_out
);

  localparam int unsigned CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic [4:0]        rd_out_q, rd_out_d;
  logic [XLEN-1:0]   hi_q, hi_d;      // mul: product high half / div: partial remainder
  logic [XLEN-1:0]   lo_q, lo_d;      // mul: multiplier then product low / div: dividend then quotient
  logic [XLEN-1:0]   opnd_q, opnd_d;  // mul: multiplicand magnitude / div: divisor
  logic [XLEN-1:0]   result_q, result_d;
  logic [XLEN-1:0]   spec_val_q, spec_val_d;
  logic              neg_q, neg_d;
  logic              spec_q, spec_d;

  // Operand conditioning at issue time
  logic              a_sgn, b_sgn, start_neg;
  logic [XLEN-1:0]   a_mag, b_mag;

  // Per-iteration datapath
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift, div_diff;

  // Final result formation
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   mul_res, div_raw, div_res, fin_res;

  // Decode which operands are signed and the sign the result must carry
  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (op)
      3'b001, 3'b100, 3'b110: begin
        a_sgn = a[XLEN-1];
        b_sgn = b[XLEN-1];
      end
      3'b010:  a_sgn = a[XLEN-1];
      default: ;
    endcase
    a_mag     = a_sgn ? -a : a;
    b_mag     = b_sgn ? -b : b;
    // REM follows the dividend only; every other signed op uses the XOR
    start_neg = a_sgn ^ (b_sgn & (op != 3'b110));
  end

  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = {hi_q, lo_q[XLEN-1]};
  // A set top bit means the trial subtraction borrowed: restore
  assign div_diff  = div_shift - {1'b0, opnd_q};

  assign prod_fix  = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
  assign mul_res   = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
  assign div_raw   = op_q[1] ? hi_q : lo_q;
  assign div_res   = neg_q ? -div_raw : div_raw;
  assign fin_res   = op_q[2] ? (spec_q ? spec_val_q : div_res) : mul_res;

  // Next-state and datapath updates for IDLE -> CALC -> DONE
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    rd_d       = rd_q;
    rd_out_d   = rd_out_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    opnd_d     = opnd_q;
    result_d   = result_q;
    spec_val_d = spec_val_q;
    neg_d      = neg_q;
    spec_d     = spec_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d       = op;
          rd_d       = rd_in;
          neg_d      = start_neg;
          spec_d     = op[2] && (b == '0);
          spec_val_d = op[1] ? a : '1;
          cnt_d      = CW'(XLEN);
          hi_d       = '0;
          lo_d       = op[2] ? a_mag : b_mag;
          opnd_d     = op[2] ? b_mag : a_mag;
          state_d    = S_CALC;
        end
      end
      S_CALC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
          if (op_q[2]) begin
            if (div_diff[XLEN]) begin
              hi_d = div_shift[XLEN-1:0];
              lo_d = {lo_q[XLEN-2:0], 1'b0};
            end else begin
              hi_d = div_diff[XLEN-1:0];
              lo_d = {lo_q[XLEN-2:0], 1'b1};
            end
          end else begin
            hi_d = mul_sum[XLEN:1];
            lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
          end
        end else begin
          result_d = fin_res;
          rd_out_d = rd_q;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      rd_out_q   <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      opnd_q     <= '0;
      result_q   <= '0;
      spec_val_q <= '0;
      neg_q      <= 1'b0;
      spec_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      rd_out_q   <= rd_out_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      opnd_q     <= opnd_d;
      result_q   <= result_d;
      spec_val_q <= spec_val_d;
      neg_q      <= neg_d;
      spec_q     <= spec_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign we_out = done && (rd_out_q != '0);
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, special cases,
// start-while-busy, mid-operation reset and randomized operations against an
// arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic [4:0]  rd_in;
  logic        busy, done, we_out;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .rd_in  (rd_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rd_out (rd_out),
    .we_out (we_out)
  );

  always #5 clk = ~clk;

  // RV32M semantics in plain 64-bit arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy, p;
    longint unsigned ux, uy, up;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (f)
      3'd0: begin up = ux * uy; return up[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * longint'(uy); return p[63:32]; end
      3'd3: begin up = ux * uy; return up[63:32]; end
      3'd4: begin
        if (y == 32'd0) return 32'hFFFF_FFFF;
        p = sx / sy;
        return p[31:0];
      end
      3'd5: begin
        if (y == 32'd0) return 32'hFFFF_FFFF;
        return x / y;
      end
      3'd6: begin
        if (y == 32'd0) return x;
        p = sx % sy;
        return p[31:0];
      end
      default: begin
        if (y == 32'd0) return x;
        return x % y;
      end
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op and follow it to completion. With noise set, start is held
  // high with fresh random operands on every cycle, including the DONE cycle.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] x,
                        input logic [31:0] y, input logic [4:0] r, input bit noise);
    int          n;
    int          dones;
    logic [31:0] exp;
    exp   = ref_model(f, x, y);
    start = 1'b1;
    op    = f;
    a     = x;
    b     = y;
    rd_in = r;
    @(posedge clk); #1;
    if (!noise) start = 1'b0;
    check({tag, ".busy_after_start"}, 32'(busy), 32'd1);
    n = 0;
    while (!done && n < 40) begin
      if (noise) begin
        op    = 3'($urandom);
        a     = $urandom;
        b     = $urandom;
        rd_in = 5'($urandom);
      end
      @(posedge clk); #1;
      n++;
    end
    check({tag, ".done_seen"}, 32'(done), 32'd1);
    check({tag, ".latency"}, n, 32'd33);
    check({tag, ".result"}, result, exp);
    check({tag, ".rd_out"}, 32'(rd_out), 32'(r));
    check({tag, ".we_out"}, 32'(we_out), 32'(r != 5'd0));
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, ".busy_low"}, 32'(busy), 32'd0);
    check({tag, ".done_pulse"}, 32'(done), 32'd0);
    check({tag, ".we_pulse"}, 32'(we_out), 32'd0);
    check({tag, ".result_hold"}, result, exp);
    if (noise) begin
      dones = 0;
      for (int i = 0; i < 5; i++) begin
        @(posedge clk); #1;
        if (done) dones++;
      end
      check({tag, ".no_extra_done"}, dones, 32'd0);
      check({tag, ".stays_idle"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int          n;
    int          dones;
    logic [2:0]  f;
    logic [31:0] x, y;

    reset = 1'b1;
    start = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    rd_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.we_out", 32'(we_out), 32'd0);
    check("rst.result", result, 32'd0);
    check("rst.rd_out", 32'(rd_out), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op("mul_12x13",   3'd0, 32'd12,         32'd13,         5'd5,  1'b0);
    check("mul_12x13.abs", result, 32'd156);
    run_op("mulhu_ff",    3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd7,  1'b0);
    check("mulhu_ff.abs", result, 32'hFFFF_FFFE);
    run_op("mulh_ff",     3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd8,  1'b0);
    check("mulh_ff.abs", result, 32'd0);
    run_op("mulhsu_m1x2", 3'd2, 32'hFFFF_FFFF,  32'd2,          5'd9,  1'b0);
    check("mulhsu_m1x2.abs", result, 32'hFFFF_FFFF);
    run_op("div_m7_2",    3'd4, 32'hFFFF_FFF9,  32'd2,          5'd10, 1'b0);
    check("div_m7_2.abs", result, 32'hFFFF_FFFD);
    run_op("rem_m7_2",    3'd6, 32'hFFFF_FFF9,  32'd2,          5'd11, 1'b0);
    check("rem_m7_2.abs", result, 32'hFFFF_FFFF);
    run_op("divu_100_7",  3'd5, 32'd100,        32'd7,          5'd12, 1'b0);
    check("divu_100_7.abs", result, 32'd14);
    run_op("remu_100_7",  3'd7, 32'd100,        32'd7,          5'd13, 1'b0);
    check("remu_100_7.abs", result, 32'd2);
    run_op("div_by0",     3'd4, 32'd5,          32'd0,          5'd14, 1'b0);
    check("div_by0.abs", result, 32'hFFFF_FFFF);
    run_op("remu_by0",    3'd7, 32'd5,          32'd0,          5'd15, 1'b0);
    check("remu_by0.abs", result, 32'd5);
    run_op("div_ovf",     3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  5'd16, 1'b0);
    check("div_ovf.abs", result, 32'h8000_0000);
    run_op("rem_ovf",     3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  5'd17, 1'b0);
    check("rem_ovf.abs", result, 32'd0);
    run_op("rem_neg_by0", 3'd6, 32'hFFFF_FF00,  32'd0,          5'd18, 1'b0);
    run_op("mul_rd0",     3'd0, 32'd3,          32'd4,          5'd0,  1'b0);
    run_op("busy_start",  3'd0, 32'd12,         32'd13,         5'd5,  1'b1);
    check("busy_start.abs", result, 32'd156);

    // Abort a DIV ten cycles in; it must never report completion
    start = 1'b1;
    op    = 3'd4;
    a     = 32'd1000;
    b     = 32'd3;
    rd_in = 5'd21;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.result", result, 32'd0);
    check("abort.rd_out", 32'(rd_out), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    dones = 0;
    n     = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || we_out) dones++;
      if (busy) n++;
    end
    check("abort.no_done", dones, 32'd0);
    check("abort.idle", n, 32'd0);
    run_op("after_abort", 3'd0, 32'd7, 32'd9, 5'd3, 1'b0);
    check("after_abort.abs", result, 32'd63);

    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom);
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 5))
        0: y = 32'd0;
        1: y = $urandom_range(1, 15);
        2: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        3: x = $urandom_range(0, 255);
        default: ;
      endcase
      run_op("rand", f, x, y, 5'($urandom), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
